// File: rtl/grid_mem_collapse.sv
// grid_mem_collapse: ROWS x COLS grid RAM with a post-reset clear sweep and a line-collapse engine.
// Define GRID_MEM_ROWFULL_EN to add full-row detection outputs.
module grid_mem_collapse #(
  parameter int DATA_W = 8,
  parameter int COL_W = 3,
  parameter int ROW_W = 5,
  localparam int ADDR_W = ROW_W + COL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic              we_a,
  output logic [DATA_W-1:0] q_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] q_b,
  input  logic              collapse_req,
  input  logic [ROW_W-1:0]  collapse_row,
  output logic              busy,
  output logic              done
`ifdef GRID_MEM_ROWFULL_EN
  ,
  output logic              row_full_valid,
  output logic [ROW_W-1:0]  row_full_idx
`endif
);
  localparam int ROWS = 2**ROW_W;
  localparam int COLS = 2**COL_W;
  typedef enum logic [2:0] {CLEAR, IDLE, COL_RD, COL_WR, TOP_CLR} state_t;
  state_t state, state_n;
  logic [ROW_W-1:0] row, row_n;
  logic [COL_W-1:0] col, col_n;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic col_last;
  assign col_last = &col;
  assign busy = state != IDLE;
  // One write source per cycle: user in IDLE, otherwise the sweep or the engine at {row, col}.
  always_comb begin
    state_n = state;
    row_n = row;
    col_n = col;
    wr_en = 1'b0;
    wr_addr = {row, col};
    wr_data = '0;
    case (state)
      CLEAR: begin
        wr_en = 1'b1;
        {row_n, col_n} = {row, col} + 1'b1;
        state_n = &{row, col} ? IDLE : CLEAR;
      end
      IDLE: begin
        wr_en = we_a;
        wr_addr = addr_a;
        wr_data = data_a;
        row_n = collapse_req ? collapse_row : row;
        col_n = collapse_req ? '0 : col;
        state_n = !collapse_req ? IDLE : (collapse_row == '0) ? TOP_CLR : COL_RD;
      end
      COL_RD: state_n = COL_WR;
      COL_WR: begin
        wr_en = 1'b1;
        wr_data = hold;
        col_n = col + 1'b1;
        row_n = col_last ? row - 1'b1 : row;
        state_n = (col_last && row == ROW_W'(1)) ? TOP_CLR : COL_RD;
      end
      TOP_CLR: begin
        wr_en = 1'b1;
        col_n = col + 1'b1;
        state_n = col_last ? IDLE : TOP_CLR;
      end
      default: state_n = CLEAR;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      row <= '0;
      col <= '0;
      done <= 1'b0;
      q_a <= '0;
      q_b <= '0;
    end else begin
      state <= state_n;
      row <= row_n;
      col <= col_n;
      done <= state == TOP_CLR && col_last;
      q_b <= mem[addr_b];
      if (state == IDLE) q_a <= we_a ? data_a : mem[addr_a];
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem[wr_addr] <= wr_data;
    if (state == COL_RD) hold <= mem[{row - 1'b1, col}];
  end
`ifdef GRID_MEM_ROWFULL_EN
  logic [COLS-1:0] occ [ROWS];
  logic full_any, rf_valid;
  logic [ROW_W-1:0] full_idx, rf_idx;
  // Last match wins, so the highest-numbered full row is reported.
  always_comb begin
    full_any = 1'b0;
    full_idx = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (&occ[i]) begin
        full_any = 1'b1;
        full_idx = ROW_W'(i);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en && !reset) occ[wr_addr[ADDR_W-1:COL_W]][wr_addr[COL_W-1:0]] <= |wr_data;
    rf_valid <= reset ? 1'b0 : full_any;
    rf_idx <= reset ? '0 : full_idx;
  end
  assign row_full_valid = rf_valid && !busy;
  assign row_full_idx = busy ? '0 : rf_idx;
`endif
endmodule

// File: tb/tb_grid_mem_collapse.sv
// tb_grid_mem_collapse: directed checks of clear sweep, port A/B timing and the collapse engine.
module tb_grid_mem_collapse;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] data_a = '0;
  logic [7:0] addr_a = '0;
  logic we_a = 1'b0;
  logic [7:0] q_a;
  logic [7:0] addr_b = '0;
  logic [7:0] q_b;
  logic collapse_req = 1'b0;
  logic [4:0] collapse_row = '0;
  logic busy, done;
  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int n, dc;
  always #5 clk = ~clk;
  grid_mem_collapse dut (
    .clk(clk), .reset(reset), .data_a(data_a), .addr_a(addr_a), .we_a(we_a), .q_a(q_a),
    .addr_b(addr_b), .q_b(q_b), .collapse_req(collapse_req), .collapse_row(collapse_row),
    .busy(busy), .done(done)
  );
  always @(posedge clk) if (done) done_cnt++;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic read_b(input string tag, input int addr, input int exp);
    addr_b = 8'(addr);
    step();
    chk($sformatf("%s@%0d", tag, addr), 32'(q_b), 32'(exp));
  endtask
  task automatic write_a(input int addr, input int val);
    we_a = 1'b1;
    addr_a = 8'(addr);
    data_a = 8'(val);
    step();
    we_a = 1'b0;
  endtask
  task automatic sweep_len(input string tag);
    n = 0;
    while (busy && n < 400) begin
      step();
      n++;
    end
    chk(tag, 32'(n), 32'd256);
  endtask
  initial begin
    repeat (3) step();
    chk("rst_q_a", 32'(q_a), 0);
    chk("rst_q_b", 32'(q_b), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 1);
    reset = 1'b0;
    sweep_len("sweep_len");
    chk("sweep_no_done", 32'(done_cnt), 0);
    for (int i = 0; i < 256; i++) read_b("sweep_zero", i, 0);
    write_a(0, 200);
    chk("wr_first_q_a", 32'(q_a), 200);
    read_b("rd_b_200", 0, 200);
    addr_b = 8'd1;
    write_a(1, 37);
    chk("b_old_data", 32'(q_b), 0);
    step();
    chk("b_new_data", 32'(q_b), 37);
    addr_a = 8'd0;
    step();
    chk("a_read", 32'(q_a), 200);
    for (int i = 0; i < 256; i++) write_a(i, (i >> 3) + 1);
    chk("fill_last_q_a", 32'(q_a), 32);
    addr_b = 8'd40;
    collapse_req = 1'b1;
    collapse_row = 5'd5;
    step();
    collapse_req = 1'b0;
    chk("c5_busy", 32'(busy), 1);
    chk("c5_b_A", 32'(q_b), 6);
    step();
    chk("c5_b_E1", 32'(q_b), 6);
    step();
    chk("c5_b_E2_old", 32'(q_b), 6);
    step();
    chk("c5_b_E3_new", 32'(q_b), 5);
    we_a = 1'b1;
    addr_a = 8'd163;
    data_a = 8'hAA;
    collapse_req = 1'b1;
    collapse_row = 5'd0;
    step();
    we_a = 1'b0;
    collapse_req = 1'b0;
    chk("c5_q_a_hold", 32'(q_a), 32);
    n = 4;
    while (busy && n < 200) begin
      step();
      n++;
    end
    chk("c5_len", 32'(n), 88);
    chk("c5_done", 32'(done), 1);
    step();
    chk("c5_done_pulse", 32'(done), 0);
    chk("c5_done_cnt", 32'(done_cnt), 1);
    chk("c5_idle", 32'(busy), 0);
    for (int i = 0; i < 256; i++)
      read_b("c5_data", i, (i >> 3) == 0 ? 0 : (i >> 3) <= 5 ? (i >> 3) : (i >> 3) + 1);
    for (int c = 0; c < 8; c++) write_a(c, 255);
    collapse_req = 1'b1;
    collapse_row = 5'd0;
    step();
    collapse_req = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    chk("c0_len", 32'(n), 8);
    chk("c0_done", 32'(done), 1);
    for (int c = 0; c < 8; c++) read_b("c0_top", c, 0);
    read_b("c0_row1", 8, 1);
    read_b("c0_row6", 55, 7);
    read_b("c0_row31", 255, 32);
    chk("c0_done_cnt", 32'(done_cnt), 2);
    collapse_req = 1'b1;
    collapse_row = 5'd10;
    step();
    collapse_req = 1'b0;
    repeat (9) step();
    chk("mid_busy", 32'(busy), 1);
    reset = 1'b1;
    step();
    chk("abort_busy", 32'(busy), 1);
    chk("abort_done", 32'(done), 0);
    chk("abort_q_a", 32'(q_a), 0);
    chk("abort_q_b", 32'(q_b), 0);
    dc = done_cnt;
    reset = 1'b0;
    sweep_len("abort_sweep_len");
    chk("abort_no_done", 32'(done_cnt), 32'(dc));
    for (int i = 0; i < 256; i++) read_b("abort_zero", i, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/grid_mem_collapse.md
Name: grid_mem_collapse

Overview:
- Parametrised successor to the 256x8 grid RAM. Holds the playfield as ROWS x COLS words, with read/write port A and read-only port B.
- Adds a timed clear sweep after reset and a hardware line-collapse engine. The engine shifts every row above a target row down by one and zeroes the top row.
- Sits between game-logic FSM (port A, collapse requests) and display scanner (port B).

Parameters:
DATA_W, 8, bits per cell word
COL_W, 3, column index bits; COLS = 2**COL_W
ROW_W, 5, row index bits; ROWS = 2**ROW_W; row 0 is the top row
ADDR_W, ROW_W+COL_W, derived, not overridable; address = {row, col}

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; aborts any operation and starts the clear sweep
data_a  in  DATA_W  write data, port A
addr_a  in  ADDR_W  address, port A
we_a  in  1  write enable, port A
q_a  out  DATA_W  registered read data, port A
addr_b  in  ADDR_W  address, port B
q_b  out  DATA_W  registered read data, port B
collapse_req  in  1  single-cycle request to collapse a row
collapse_row  in  ROW_W  row to remove; sampled with collapse_req
busy  out  1  clear sweep or collapse in progress
done  out  1  one-cycle pulse when a collapse completes

Behaviour:
- Reset values: q_a=0, q_b=0, done=0, busy=1.
- Clear sweep: while reset=1, the sweep address is held at 0. After reset falls, one word is zeroed per cycle, addresses 0 to 2**ADDR_W-1.
- busy falls on the cycle after address 2**ADDR_W-1 is written. No done pulse is issued for a sweep.
- FSM states: CLEAR, IDLE, COL_RD, COL_WR, TOP_CLR.
- Port A in IDLE:
  - read latency is 1 cycle;
  - write-first, so a write to addr_a puts data_a on q_a at the same edge.
- Port B is always live, including during busy. Latency is 1 cycle. If port B reads the address being written in the same cycle, it returns the old data.
- While busy:
  - port A writes are dropped;
  - q_a holds its last value;
  - collapse_req is ignored.
- Collapse: accepted only in IDLE with collapse_req=1. Sample T=collapse_row and set busy on the next edge.
  - For r = T down to 1, for c = 0 to COLS-1:
    - COL_RD: read {r-1,c};
    - COL_WR: write that value to {r,c}.
    - Each word costs 2 cycles.
  - TOP_CLR: write 0 to {0,c} for c = 0 to COLS-1, 1 cycle each.
  - Total busy cycles = 2*COLS*T + COLS. With T=0, only the top row is cleared (COLS cycles).
  - done pulses for one cycle and busy falls on the cycle after the last TOP_CLR write. The FSM then returns to IDLE.
- Simultaneous events:
  - reset wins over everything;
  - collapse_req together with we_a in IDLE: the write executes this cycle and the collapse starts next cycle, so the written value takes part in the collapse.
- Reset mid-collapse: abort immediately, no done pulse, enter CLEAR.
- Address arithmetic wraps at ADDR_W bits; no out-of-range addresses exist.

Optional Feature:
- Macro: GRID_MEM_ROWFULL_EN.
- When defined, adds outputs row_full_valid (1 bit) and row_full_idx (ROW_W bits). The block keeps a flop array of ROWS x COLS occupancy bits, where bit = (word != 0).
- Occupancy bits track every write: user writes, engine writes and the clear sweep.
- row_full_valid=1 when any row has all COLS bits set. row_full_idx is the highest-numbered (lowest on screen) such row.
- Both are registered, so they are valid 1 cycle after the causing write.
- Both read 0 while busy.
- When undefined, neither port nor array exists.

Test Plan:
- Reset held 3 cycles then released -> busy=1 for exactly 256 cycles after release. All 256 addresses then read 0 on port B.
- Write 200 to addr_a=0 -> q_a=200 at the same edge. Read addr_b=0 next cycle -> q_b=200. Write 37 to addr 1 while addr_b=1 -> q_b shows old value 0, then 37 next cycle.
- Fill row r with value r+1 for all rows, then collapse_row=5:
  - busy lasts 2*8*5+8=88 cycles, then done pulses once;
  - rows 1..5 read 1..5 (old rows 0..4), row 0 reads 0, rows 6..31 unchanged.
- collapse_row=0 with row 0 = 0xFF -> busy lasts 8 cycles, row 0 reads 0, other rows unchanged.
- Mid-collapse port A write of 0xAA -> dropped. Port B reads during collapse return in-progress contents. A second collapse_req is ignored.
- Reset asserted 10 cycles into a collapse -> no done pulse, clear sweep runs, all words read 0. With GRID_MEM_ROWFULL_EN, filling row 31 nonzero -> row_full_valid=1 and row_full_idx=31 one cycle after the last write.
